// File: rtl/udp_rcv_ring.sv
// rtl/udp_rcv_ring.sv - MAC receive frames into a circular packet buffer with per-packet descriptors
module udp_rcv_ring #(
  parameter int DW       = 32,
  parameter int MODW     = 2,
  parameter int AW       = 10,
  parameter int INT_HOLD = 10,
  parameter int DROP_ERR = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   rx_data,
  input  logic            rx_sop,
  input  logic            rx_eop,
  input  logic            rx_dval,
  input  logic [MODW-1:0] rx_mod,
  input  logic [5:0]      rx_err,
  input  logic [17:0]     rx_err_stat,
  input  logic [3:0]      rx_frm_type,
  output logic            rx_rdy,
  output logic            mem_wren,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_data,
  output logic            desc_wr,
  output logic [AW-1:0]   desc_start,
  output logic [15:0]     desc_words,
  output logic [15:0]     desc_bytes,
  output logic [31:0]     desc_stat,
  input  logic            rel_valid,
  input  logic [AW:0]     rel_words,
  output logic            int_rsv,
  output logic [15:0]     drop_cnt
);

  localparam int BPW = DW / 8;

  typedef enum logic [1:0] {IDLE, RECV, DESC, DROP} state_t;

  state_t        state, state_n;
  logic [AW-1:0] wr_ptr, pkt_start;
  logic [AW:0]   used, pkt_len;
  logic [15:0]   pkt_cnt;
  logic [7:0]    int_timer;

  logic          accept, full, err_hit;
  logic          wr_en, new_pkt, finish, rb_old;
  logic          commit, err_drop, ovf, sop_drop;
  logic [AW-1:0] wr_base, cur_start, ptr_n;
  logic [15:0]   cnt_n;
  logic [AW:0]   len_n, used_n;
  logic [AW+1:0] used_sum;
  logic [16:0]   drop_sum;
  logic [15:0]   drop_n;
  logic [DW-1:0] wr_data;

  assign accept  = rx_dval && rx_rdy;
  // used never exceeds the depth, so the top bit alone marks a full buffer
  assign full    = (used == {1'b1, {AW{1'b0}}});
  assign err_hit = (DROP_ERR != 0) && (rx_err != 6'd0);

  // Beat classification: what the current beat does to the packet and the FSM
  always_comb begin
    state_n  = state;
    wr_en    = 1'b0;
    new_pkt  = 1'b0;
    finish   = 1'b0;
    rb_old   = 1'b0;
    commit   = 1'b0;
    err_drop = 1'b0;
    ovf      = 1'b0;
    sop_drop = 1'b0;
    wr_base  = wr_ptr;
    case (state)
      IDLE: begin
        if (accept && rx_sop) begin
          if (full) begin
            ovf     = 1'b1;
            state_n = rx_eop ? IDLE : DROP;
          end else begin
            wr_en   = 1'b1;
            new_pkt = 1'b1;
            finish  = rx_eop;
            state_n = RECV;
          end
        end
      end
      RECV: begin
        if (accept) begin
          if (rx_sop) begin
            // missing eop: the old packet is abandoned and the new one reuses its space
            sop_drop = 1'b1;
            rb_old   = 1'b1;
            wr_en    = 1'b1;
            new_pkt  = 1'b1;
            wr_base  = pkt_start;
            finish   = rx_eop;
          end else if (full) begin
            ovf     = 1'b1;
            rb_old  = 1'b1;
            state_n = rx_eop ? IDLE : DROP;
          end else begin
            wr_en  = 1'b1;
            finish = rx_eop;
          end
        end
      end
      DESC: state_n = IDLE;
      DROP: begin
        if (accept && rx_eop) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (finish) begin
      if (err_hit) begin
        err_drop = 1'b1;
        state_n  = IDLE;
        if (!new_pkt) rb_old = 1'b1;
      end else begin
        commit  = 1'b1;
        state_n = DESC;
      end
    end
  end

  // Pointer, occupancy, counters and masked write data for this beat
  always_comb begin
    cur_start = new_pkt ? wr_base : pkt_start;
    cnt_n     = new_pkt ? 16'd1 : ((pkt_cnt == 16'hFFFF) ? 16'hFFFF : pkt_cnt + 16'd1);
    len_n     = new_pkt ? {{AW{1'b0}}, 1'b1} : pkt_len + {{AW{1'b0}}, 1'b1};
    ptr_n     = wr_ptr;
    if (err_drop || (ovf && rb_old)) ptr_n = cur_start;
    else if (wr_en)                 ptr_n = wr_base + {{(AW-1){1'b0}}, 1'b1};
    // an error-dropped eop word is written but never counted as occupied
    used_sum  = {1'b0, used}
              + {{(AW+1){1'b0}}, (wr_en && !err_drop)}
              - (rb_old ? {1'b0, pkt_len} : '0);
    used_n    = used_sum[AW:0];
    if (rel_valid) begin
      if ({1'b0, rel_words} >= used_sum) used_n = '0;
      else                               used_n = AW'(used_sum - {1'b0, rel_words}) == '0 && used_sum[AW] == 1'b0 ?
                                                  '0 : (used_sum[AW:0] - rel_words);
    end
    drop_sum  = {1'b0, drop_cnt} + 17'(sop_drop) + 17'(err_drop) + 17'(ovf);
    drop_n    = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    wr_data   = rx_data;
    if (rx_eop) begin
      for (int b = 0; b < BPW; b++) begin
        if (b < int'(rx_mod)) wr_data[8*b +: 8] = 8'h00;
      end
    end
  end

  // FSM state, buffer writes, descriptor, interrupt stretch and drop counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      rx_rdy     <= 1'b0;
      mem_wren   <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      desc_wr    <= 1'b0;
      desc_start <= '0;
      desc_words <= '0;
      desc_bytes <= '0;
      desc_stat  <= '0;
      int_rsv    <= 1'b0;
      int_timer  <= '0;
      drop_cnt   <= '0;
      wr_ptr     <= '0;
      pkt_start  <= '0;
      used       <= '0;
      pkt_len    <= '0;
      pkt_cnt    <= '0;
    end else begin
      state    <= state_n;
      rx_rdy   <= (state_n != DESC);
      mem_wren <= wr_en;
      if (wr_en) begin
        mem_addr <= wr_base;
        mem_data <= wr_data;
        pkt_cnt  <= cnt_n;
        pkt_len  <= len_n;
      end
      if (new_pkt) pkt_start <= wr_base;
      wr_ptr   <= ptr_n;
      used     <= used_n;
      drop_cnt <= drop_n;
      desc_wr  <= commit;
      if (commit) begin
        desc_start <= cur_start;
        desc_words <= cnt_n;
        desc_bytes <= 16'(32'(cnt_n) * BPW - 32'(rx_mod));
        desc_stat  <= 32'({rx_mod, rx_frm_type, rx_err, rx_err_stat});
      end
      if (commit) begin
        int_timer <= 8'(INT_HOLD);
        int_rsv   <= 1'b1;
      end else if (int_timer > 8'd1) begin
        int_timer <= int_timer - 8'd1;
      end else begin
        int_timer <= 8'd0;
        int_rsv   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_udp_rcv_ring.sv
// tb/tb_udp_rcv_ring.sv - scoreboard bench for udp_rcv_ring
module tb_udp_rcv_ring;
  localparam int AW = 4;
  localparam logic [3:0]  FRM  = 4'h5;
  localparam logic [17:0] STAT = 18'h2A5C3;

  typedef struct packed {
    logic [3:0]  start;
    logic [15:0] words;
    logic [15:0] bytes;
    logic [31:0] stat;
  } desc_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] rx_data = '0;
  logic        rx_sop = 1'b0, rx_eop = 1'b0, rx_dval = 1'b0;
  logic [1:0]  rx_mod = '0;
  logic [5:0]  rx_err = '0;
  logic [17:0] rx_err_stat = '0;
  logic [3:0]  rx_frm_type = '0;
  logic        rx_rdy, mem_wren, desc_wr, int_rsv;
  logic [3:0]  mem_addr, desc_start;
  logic [31:0] mem_data, desc_stat;
  logic [15:0] desc_words, desc_bytes, drop_cnt;
  logic        rel_valid = 1'b0;
  logic [4:0]  rel_words = '0;

  int vectors = 0, miscompares = 0, desc_seen = 0, int_run = 0, last_run = 0;
  logic [3:0]  wq_addr[$];
  logic [31:0] wq_data[$];
  desc_t       dq[$];
  logic [7:0]  tag = 8'h10;

  wire [123:0] all_out = {rx_rdy, mem_wren, mem_addr, mem_data, desc_wr, desc_start,
                          desc_words, desc_bytes, desc_stat, int_rsv, drop_cnt};

  always #5 clk = ~clk;

  udp_rcv_ring #(.DW(32), .MODW(2), .AW(AW), .INT_HOLD(10), .DROP_ERR(1)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_sop(rx_sop), .rx_eop(rx_eop),
    .rx_dval(rx_dval), .rx_mod(rx_mod), .rx_err(rx_err), .rx_err_stat(rx_err_stat),
    .rx_frm_type(rx_frm_type), .rx_rdy(rx_rdy), .mem_wren(mem_wren), .mem_addr(mem_addr),
    .mem_data(mem_data), .desc_wr(desc_wr), .desc_start(desc_start), .desc_words(desc_words),
    .desc_bytes(desc_bytes), .desc_stat(desc_stat), .rel_valid(rel_valid),
    .rel_words(rel_words), .int_rsv(int_rsv), .drop_cnt(drop_cnt)
  );

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic put_beat(input logic [31:0] d, input bit sop, input bit eop,
                          input logic [1:0] mod, input logic [5:0] err);
    int w = 0;
    while (rx_rdy !== 1'b1 && w < 20) begin @(posedge clk); #1; w++; end
    vectors++;
    if (w >= 20) begin
      miscompares++;
      $display("FAIL rdy_wait: rx_rdy %b after %0d cycles, required 1", rx_rdy, w);
    end
    rx_data = d; rx_sop = sop; rx_eop = eop; rx_mod = mod; rx_err = err;
    rx_frm_type = FRM; rx_err_stat = STAT; rx_dval = 1'b1;
    @(posedge clk); #1;
    rx_dval = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
  endtask

  task automatic send_frame(input int n, input int base, input int nwr, input logic [1:0] mod,
                            input logic [5:0] err, input bit no_eop, input bit exp_desc);
    desc_t e;
    for (int i = 0; i < n; i++) begin
      logic [31:0] d;
      bit last;
      d = {tag, 8'(i), 16'hC35A ^ 16'(i * 7)};
      last = (i == n - 1) && !no_eop;
      if (i < nwr) begin
        wq_addr.push_back(4'(base + i));
        wq_data.push_back(last ? (d & (32'hFFFFFFFF << (8 * mod))) : d);
      end
      put_beat(d, i == 0, last, mod, err);
    end
    if (exp_desc) begin
      e.start = 4'(base);
      e.words = 16'(n);
      e.bytes = 16'(n * 4 - int'(mod));
      e.stat  = {2'b00, mod, FRM, err, STAT};
      dq.push_back(e);
    end
    tag = tag + 8'h01;
  endtask

  task automatic release_words(input int n);
    rel_valid = 1'b1; rel_words = 5'(n);
    @(posedge clk); #1;
    rel_valid = 1'b0; rel_words = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (all_out !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h, required 0", all_out);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (rx_rdy !== 1'b0) begin
      miscompares++;
      $display("FAIL rdy_before_clock: got %b, required 0", rx_rdy);
    end
    @(posedge clk); #1;
    vectors++;
    if (rx_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL rdy_after_release: got %b, required 1", rx_rdy);
    end
  endtask

  task automatic test_basic();
    int d0 = desc_seen;
    send_frame(4, 0, 4, 2'd1, 6'd0, 0, 1);
    wait_cycles(15);
    vectors++;
    if (desc_seen - d0 !== 1) begin
      miscompares++;
      $display("FAIL basic_desc_count: got %0d, required 1", desc_seen - d0);
    end
    vectors++;
    if (last_run !== 10) begin
      miscompares++;
      $display("FAIL int_hold: high %0d cycles, required 10", last_run);
    end
    release_words(4);
  endtask

  task automatic test_err_drop();
    int d0 = desc_seen;
    send_frame(3, 4, 3, 2'd0, 6'h01, 0, 0);
    wait_cycles(2);
    vectors++;
    if (drop_cnt !== 16'd1 || desc_seen !== d0) begin
      miscompares++;
      $display("FAIL err_drop: drop_cnt %0d desc %0d, required 1 and %0d", drop_cnt, desc_seen, d0);
    end
    send_frame(2, 4, 2, 2'd2, 6'd0, 0, 1);
    wait_cycles(3);
    vectors++;
    if (desc_seen - d0 !== 1) begin
      miscompares++;
      $display("FAIL err_next_commit: got %0d descriptors, required 1", desc_seen - d0);
    end
    release_words(2);
  endtask

  task automatic test_sop_restart();
    send_frame(3, 6, 3, 2'd0, 6'd0, 1, 0);
    send_frame(4, 6, 4, 2'd3, 6'd0, 0, 1);
    wait_cycles(3);
    vectors++;
    if (drop_cnt !== 16'd2) begin
      miscompares++;
      $display("FAIL sop_restart_drop: got %0d, required 2", drop_cnt);
    end
    release_words(4);
  endtask

  task automatic test_wrap();
    send_frame(4, 10, 4, 2'd0, 6'd0, 0, 1);
    release_words(4);
    send_frame(4, 14, 4, 2'd1, 6'd0, 0, 1);
    wait_cycles(3);
    vectors++;
    if (desc_start !== 4'd14) begin
      miscompares++;
      $display("FAIL wrap_start: got %0d, required 14", desc_start);
    end
    release_words(4);
  endtask

  task automatic test_overflow();
    send_frame(20, 2, 16, 2'd0, 6'd0, 0, 0);
    wait_cycles(2);
    vectors++;
    if (drop_cnt !== 16'd3) begin
      miscompares++;
      $display("FAIL overflow_drop: got %0d, required 3", drop_cnt);
    end
    release_words(16);
    send_frame(3, 2, 3, 2'd0, 6'd0, 0, 1);
    wait_cycles(3);
    vectors++;
    if (drop_cnt !== 16'd3 || desc_words !== 16'd3) begin
      miscompares++;
      $display("FAIL overflow_recover: drop %0d words %0d, required 3 and 3", drop_cnt, desc_words);
    end
    release_words(3);
  endtask

  task automatic test_back_to_back();
    wait_cycles(12);
    send_frame(1, 5, 1, 2'd0, 6'd0, 0, 1);
    wait_cycles(3);
    send_frame(1, 6, 1, 2'd0, 6'd0, 0, 1);
    wait_cycles(20);
    vectors++;
    if (last_run !== 14) begin
      miscompares++;
      $display("FAIL int_restart: high %0d cycles, required 14", last_run);
    end
    release_words(2);
  endtask

  task automatic test_reset_mid_frame();
    int d0 = desc_seen;
    send_frame(3, 7, 3, 2'd0, 6'd0, 1, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (all_out !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: got %h, required 0", all_out);
    end
    rst = 1'b1;
    wait_cycles(1);
    send_frame(2, 0, 2, 2'd0, 6'd0, 0, 1);
    wait_cycles(3);
    vectors++;
    if (desc_seen - d0 !== 1 || drop_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL mid_reset_after: desc %0d drop %0d, required 1 and 0", desc_seen - d0, drop_cnt);
    end
  endtask

  initial begin
    fork
      begin : monitor
        logic [3:0]  ea;
        logic [31:0] ed;
        desc_t       ex;
        logic        prev_desc;
        prev_desc = 1'b0;
        forever begin
          @(negedge clk);
          if (mem_wren === 1'b1) begin
            vectors++;
            if (wq_addr.size() == 0) begin
              miscompares++;
              $display("FAIL unexpected_write: addr %0d data %h, none expected", mem_addr, mem_data);
            end else begin
              ea = wq_addr.pop_front();
              ed = wq_data.pop_front();
              if (mem_addr !== ea || mem_data !== ed) begin
                miscompares++;
                $display("FAIL write: got %0d/%h, required %0d/%h", mem_addr, mem_data, ea, ed);
              end
            end
          end
          if (desc_wr === 1'b1) begin
            desc_seen++;
            vectors++;
            if (dq.size() == 0) begin
              miscompares++;
              $display("FAIL unexpected_desc: start %0d words %0d", desc_start, desc_words);
            end else begin
              ex = dq.pop_front();
              if ({desc_start, desc_words, desc_bytes, desc_stat} !== ex) begin
                miscompares++;
                $display("FAIL desc: got %0d/%0d/%0d/%h, required %0d/%0d/%0d/%h",
                         desc_start, desc_words, desc_bytes, desc_stat,
                         ex.start, ex.words, ex.bytes, ex.stat);
              end
            end
            vectors++;
            if (prev_desc !== 1'b0) begin
              miscompares++;
              $display("FAIL desc_width: desc_wr high %b on previous cycle too, required 0", prev_desc);
            end
          end
          prev_desc = (desc_wr === 1'b1);
          if (int_rsv === 1'b1) int_run++;
          else begin
            if (int_run != 0) last_run = int_run;
            int_run = 0;
          end
        end
      end
      begin : tests
        test_reset();
        test_basic();
        test_err_drop();
        test_sop_restart();
        test_wrap();
        test_overflow();
        test_back_to_back();
        test_reset_mid_frame();
        wait_cycles(2);
        vectors++;
        if (wq_addr.size() != 0 || dq.size() != 0) begin
          miscompares++;
          $display("FAIL pending: %0d writes %0d descriptors outstanding, required 0",
                   wq_addr.size(), dq.size());
        end
      end
      begin : watchdog
        #200000;
        miscompares++;
        $display("FAIL timeout: bench still running at %0t, required completion", $time);
      end
    join_any
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/udp_rcv_ring.md
Name: udp_rcv_ring

Overview:
- Parametrised successor of the MAC-side UDP receiver.
- Accepts frames from the Ethernet MAC receive FIFO interface and writes their words into a circular packet buffer of 2**AW words, tracking the write address in hardware.
- Emits one descriptor per committed packet: start address, word count, byte count, status.
- Drops errored or overflowing packets by rolling back the write pointer, raises a stretched interrupt to the MCU, and takes buffer-space releases from the consumer.

Parameters:
- DW, 32, data width in bits; multiple of 8, 32..128.
- MODW, 2, width of rx_mod; equals log2(DW/8).
- AW, 10, packet buffer word-address width; depth = 2**AW words.
- INT_HOLD, 10, int_rsv high time in clk cycles after a commit; 1..255.
- DROP_ERR, 1, 1 = drop frames with rx_err!=0 at eop; 0 = commit them with status.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- rx_data  in  DW  MAC receive data
- rx_sop  in  1  start of packet, qualified by rx_dval
- rx_eop  in  1  end of packet, qualified by rx_dval
- rx_dval  in  1  data valid
- rx_mod  in  MODW  number of unused low-order bytes in the eop word
- rx_err  in  6  MAC error flags, valid at eop
- rx_err_stat  in  18  MAC error statistics, valid at eop
- rx_frm_type  in  4  frame type, valid at eop
- rx_rdy  out  1  ready to MAC
- mem_wren  out  1  buffer write enable
- mem_addr  out  AW  buffer write address
- mem_data  out  DW  buffer write data
- desc_wr  out  1  one-cycle descriptor strobe
- desc_start  out  AW  address of the packet's first word
- desc_words  out  16  packet length in words
- desc_bytes  out  16  packet length in bytes
- desc_stat  out  32  {2'b00, rx_mod, rx_frm_type, rx_err, rx_err_stat}, latched at eop
- rel_valid  in  1  consumer frees buffer space
- rel_words  in  AW+1  number of words freed
- int_rsv  out  1  packet-received interrupt
- drop_cnt  out  16  dropped-packet counter, saturating

Behaviour:
- Reset: one clock; reset is synchronous and active-low (rst=0 resets on clk rising edge).
- In reset: all outputs 0; wr_ptr, pkt_start, used, int timer all 0; state IDLE. rx_rdy goes to 1 on the first clock after release.
- States:
  - IDLE: rx_rdy=1. A beat with rx_dval&rx_sop starts a packet: pkt_start<=wr_ptr, word count=1, word written. A beat with rx_dval and no rx_sop is ignored (no write).
  - RECV: every rx_dval beat is written at wr_ptr. wr_ptr increments mod 2**AW (wraps 2**AW-1 -> 0). used and word count increment.
  - DESC: one cycle. desc_wr=1, rx_rdy=0. Next state IDLE.
  - DROP: rx_rdy=1. Beats are discarded until rx_dval&rx_eop, then IDLE.
- Write timing: registered, one cycle latency. mem_wren/mem_addr/mem_data appear the cycle after the accepted beat.
- Last-word masking: the eop word has its rx_mod low-order bytes forced to 0.
- Byte count: desc_bytes = (words-1)*(DW/8) + (DW/8 - rx_mod).
- Commit at eop: if DROP_ERR=0 or rx_err==0, latch the descriptor fields and go to DESC. used keeps the packet words.
- Error drop: if DROP_ERR=1 and rx_err!=0 at eop, set wr_ptr<=pkt_start, subtract the packet words from used, increment drop_cnt, go to IDLE. No desc_wr.
- Overflow: a beat arriving with used==2**AW is not written. Roll back as in the error drop, increment drop_cnt, go to DROP; or go to IDLE if that beat is eop.
- sop during RECV (missing eop): roll back the current packet and increment drop_cnt. The sop beat starts the new packet in the same cycle.
- sop&eop on the same beat: a 1-word packet.
- Word count saturation: word count saturates at 16'hFFFF; the packet is still committed.
- Release: on rel_valid, used decreases by rel_words, clamped at 0. A release and a write in the same cycle are both applied (used + 1 - rel_words).
- Interrupt: on desc_wr, int_rsv=1 for exactly INT_HOLD cycles. A new desc_wr while high restarts the count.
- Reset mid-packet: the packet is discarded and no descriptor is issued.

Test Plan:
- 4-word frame, DW=32, rx_mod=1, rx_err=0 -> mem_addr 0..3, word 3 low byte 00. Then desc_wr one cycle with desc_start=0, words=4, bytes=15. int_rsv high 10 cycles.
- rx_err=6'h01 at eop, DROP_ERR=1 -> no desc_wr, drop_cnt=1. The next frame starts at the same address as the dropped one.
- AW=4, no release, 20-word frame -> 16 writes then drop, drop_cnt=1, state DROP until eop. rel_valid with rel_words=16 -> next 3-word frame commits at desc_start=0.
- wr_ptr=14, AW=4, 4-word frame (prior space released) -> addresses 14,15,0,1; desc_start=14.
- sop at beat 3 of an unfinished frame -> drop_cnt+1; the new frame's desc_start equals the old pkt_start.
- Two commits 4 cycles apart with INT_HOLD=10 -> int_rsv continuously high for 14 cycles. rst=0 mid-frame -> all outputs 0 next clk.
